alu_exec_ctrl: RTL and testbench

//  Sequencer in front of the 32-bit ARM ALU. Accepts one data-processing op per handshake
//  and evaluates its ARM condition against the architectural NZCV flag register held here.

---
 rtl/alu_pkg.sv | 56 +++++
 rtl/alu_exec_ctrl_cond_check.sv | 35 +++
 rtl/alu_exec_ctrl.sv | 126 ++++++++++++
 tb/tb_alu_exec_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute sequencer: opcode and condition
// encodings, FSM state encoding and opcode classification helpers.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // TST/TEQ/CMP/CMN occupy 8..B: flags always written, no register write.
  function automatic logic is_compare(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

  function automatic logic is_logical(input logic [3:0] op);
    case (op)
      OP_AND, OP_EOR, OP_TST, OP_TEQ,
      OP_ORR, OP_MOV, OP_BIC, OP_MVN: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_cond_check.sv
// Combinational ARM condition-code evaluation against an NZCV flag vector.
module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ: pass = z;
      CC_NE: pass = ~z;
      CC_CS: pass = c;
      CC_CC: pass = ~c;
      CC_MI: pass = n;
      CC_PL: pass = ~n;
      CC_VS: pass = v;
      CC_VC: pass = ~v;
      CC_HI: pass = c & ~z;
      CC_LS: pass = ~c | z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = ~z & (n == v);
      CC_LE: pass = z | (n != v);
      CC_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: registers one op, drives the external ALU for one
// cycle, applies condition/flag rules and holds a write-back response.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int DW    = 32,
  parameter int RW    = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // a source holds valid and payload stable until that edge.
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cond,
  input  logic [3:0]       req_opcode,
  input  logic             req_s,
  input  logic [RW-1:0]    req_rd,
  input  logic [DW-1:0]    req_a,
  input  logic [DW-1:0]    req_b,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  output logic [3:0]       alu_opcode,
  output logic             alu_carry_in,
  input  logic [DW-1:0]    alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [RW-1:0]    wb_rd,
  output logic [DW-1:0]    wb_data,
  output logic             wb_we,
  input  logic             flag_wr_en,
  input  logic [3:0]       flag_wr_data,
  output logic [3:0]       flags_nzcv,
  output logic [CNT_W-1:0] ops_retired,
  output logic [1:0]       dbg_state
);

  logic [1:0]    state;
  logic [3:0]    cond_q;
  logic [3:0]    opcode_q;
  logic          s_q;
  logic [RW-1:0] rd_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic          cond_pass;
  logic          flag_upd;

  cond_check u_cond_check (
    .cond (cond_q),
    .nzcv (flags_nzcv),
    .pass (cond_pass)
  );

  assign req_ready    = (state == ST_IDLE);
  assign wb_valid     = (state == ST_RESP);
  assign dbg_state    = state;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_opcode   = opcode_q;
  assign alu_carry_in = flags_nzcv[1];

  assign flag_upd = (state == ST_EXEC) && cond_pass && (s_q || is_compare(opcode_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cond_q      <= '0;
      opcode_q    <= '0;
      s_q         <= 1'b0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      wb_rd       <= '0;
      wb_data     <= '0;
      wb_we       <= 1'b0;
      ops_retired <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cond_q   <= req_cond;
            opcode_q <= req_opcode;
            s_q      <= req_s;
            rd_q     <= req_rd;
            a_q      <= req_a;
            b_q      <= req_b;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          wb_data <= alu_result;
          wb_rd   <= rd_q;
          wb_we   <= cond_pass && !is_compare(opcode_q);
          state   <= ST_RESP;
        end
        ST_RESP: begin
          if (wb_ready) begin
            ops_retired <= ops_retired + 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // An EXEC flag update takes priority over a same-cycle MSR write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_nzcv <= 4'b0000;
    end else if (flag_upd) begin
      if (is_logical(opcode_q))
        flags_nzcv <= {alu_n, alu_z, flags_nzcv[1:0]};
      else
        flags_nzcv <= {alu_n, alu_z, alu_c, alu_v};
    end else if (flag_wr_en) begin
      flags_nzcv <= flag_wr_data;
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a small behavioural ARM ALU beside it.
module tb_alu_exec_ctrl;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int RW = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_cond;
  logic [3:0]       req_opcode;
  logic             req_s;
  logic [RW-1:0]    req_rd;
  logic [DW-1:0]    req_a;
  logic [DW-1:0]    req_b;
  logic [DW-1:0]    alu_a;
  logic [DW-1:0]    alu_b;
  logic [3:0]       alu_opcode;
  logic             alu_carry_in;
  logic [DW-1:0]    alu_result;
  logic             alu_n, alu_z, alu_c, alu_v;
  logic             wb_valid;
  logic             wb_ready;
  logic [RW-1:0]    wb_rd;
  logic [DW-1:0]    wb_data;
  logic             wb_we;
  logic             flag_wr_en;
  logic [3:0]       flag_wr_data;
  logic [3:0]       flags_nzcv;
  logic [CNT_W-1:0] ops_retired;
  logic [1:0]       dbg_state;

  int n_assert;
  int n_fail;

  alu_exec_ctrl #(.DW(DW), .RW(RW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cond     (req_cond),
    .req_opcode   (req_opcode),
    .req_s        (req_s),
    .req_rd       (req_rd),
    .req_a        (req_a),
    .req_b        (req_b),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_carry_in (alu_carry_in),
    .alu_result   (alu_result),
    .alu_n        (alu_n),
    .alu_z        (alu_z),
    .alu_c        (alu_c),
    .alu_v        (alu_v),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_we        (wb_we),
    .flag_wr_en   (flag_wr_en),
    .flag_wr_data (flag_wr_data),
    .flags_nzcv   (flags_nzcv),
    .ops_retired  (ops_retired),
    .dbg_state    (dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ARM ALU model: arithmetic ops as x + y + ci, logical ops pass carry through.
  logic [DW-1:0] m_x, m_y;
  logic          m_ci;
  logic [DW:0]   m_sum;
  logic          m_arith;

  always_comb begin
    m_x = alu_a;
    m_y = alu_b;
    m_ci = 1'b0;
    m_arith = 1'b1;
    case (alu_opcode)
      OP_SUB, OP_CMP: begin m_y = ~alu_b; m_ci = 1'b1; end
      OP_RSB:         begin m_x = alu_b; m_y = ~alu_a; m_ci = 1'b1; end
      OP_ADD, OP_CMN: m_ci = 1'b0;
      OP_ADC:         m_ci = alu_carry_in;
      OP_SBC:         begin m_y = ~alu_b; m_ci = alu_carry_in; end
      OP_RSC:         begin m_x = alu_b; m_y = ~alu_a; m_ci = alu_carry_in; end
      default:        m_arith = 1'b0;
    endcase
    m_sum = {1'b0, m_x} + {1'b0, m_y} + {{DW{1'b0}}, m_ci};
    alu_result = m_sum[DW-1:0];
    alu_c = m_sum[DW];
    alu_v = (m_x[DW-1] == m_y[DW-1]) && (m_sum[DW-1] != m_x[DW-1]);
    if (!m_arith) begin
      case (alu_opcode)
        OP_AND, OP_TST: alu_result = alu_a & alu_b;
        OP_EOR, OP_TEQ: alu_result = alu_a ^ alu_b;
        OP_ORR:         alu_result = alu_a | alu_b;
        OP_MOV:         alu_result = alu_b;
        OP_BIC:         alu_result = alu_a & ~alu_b;
        default:        alu_result = ~alu_b;
      endcase
      alu_c = alu_carry_in;
      alu_v = 1'b0;
    end
    alu_n = alu_result[DW-1];
    alu_z = (alu_result == '0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from post-edge time; returns one cycle into RESP.
  task automatic do_op(input logic [3:0] cond, input logic [3:0] op, input logic s,
                       input logic [RW-1:0] rd, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic msr_en, input logic [3:0] msr_data);
    req_cond = cond; req_opcode = op; req_s = s; req_rd = rd; req_a = a; req_b = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    flag_wr_en = msr_en;
    flag_wr_data = msr_data;
    chk("exec_state", 32'(dbg_state), 32'(ST_EXEC));
    chk("exec_no_wb", 32'(wb_valid), 32'd0);
    @(posedge clk); #1;
    flag_wr_en = 1'b0;
    chk("resp_wb_valid", 32'(wb_valid), 32'd1);
  endtask

  task automatic accept();
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    chk("back_idle", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic msr(input logic [3:0] d);
    flag_wr_en = 1'b1;
    flag_wr_data = d;
    @(posedge clk); #1;
    flag_wr_en = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_cond = '0; req_opcode = '0; req_s = 1'b0;
    req_rd = '0; req_a = '0; req_b = '0;
    wb_ready = 1'b0; flag_wr_en = 1'b0; flag_wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: reset values, then ADDS overflow
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_flags", 32'(flags_nzcv), 32'd0);
    chk("rst_ops", 32'(ops_retired), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    do_op(CC_AL, OP_ADD, 1'b1, 4'd3, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'h0);
    chk("t1_data", wb_data, 32'h8000_0000);
    chk("t1_we", 32'(wb_we), 32'd1);
    chk("t1_rd", 32'(wb_rd), 32'd3);
    chk("t1_flags", 32'(flags_nzcv), 32'b1001);
    accept();
    chk("t1_ops", 32'(ops_retired), 32'd1);

    // 2: CMP equal sets Z and C, then SUB EQ passes
    do_op(CC_AL, OP_CMP, 1'b0, 4'd1, 32'd5, 32'd5, 1'b0, 4'h0);
    chk("t2_cmp_we", 32'(wb_we), 32'd0);
    chk("t2_cmp_flags", 32'(flags_nzcv), 32'b0110);
    accept();
    do_op(CC_EQ, OP_SUB, 1'b0, 4'd2, 32'd9, 32'd4, 1'b0, 4'h0);
    chk("t2_sub_data", wb_data, 32'd5);
    chk("t2_sub_we", 32'(wb_we), 32'd1);
    chk("t2_sub_flags", 32'(flags_nzcv), 32'b0110);
    accept();
    chk("t2_ops", 32'(ops_retired), 32'd3);

    // 3: Z=0 via MSR; NE passes, EQ fails but still retires
    msr(4'b0000);
    chk("t3_msr", 32'(flags_nzcv), 32'd0);
    do_op(CC_NE, OP_ADD, 1'b0, 4'd4, 32'd2, 32'd3, 1'b0, 4'h0);
    chk("t3_ne_we", 32'(wb_we), 32'd1);
    chk("t3_ne_data", wb_data, 32'd5);
    accept();
    chk("t3_ne_ops", 32'(ops_retired), 32'd4);
    do_op(CC_EQ, OP_ADD, 1'b1, 4'd4, 32'd2, 32'd3, 1'b0, 4'h0);
    chk("t3_eq_we", 32'(wb_we), 32'd0);
    chk("t3_eq_data", wb_data, 32'd5);
    chk("t3_eq_flags", 32'(flags_nzcv), 32'd0);
    accept();
    chk("t3_eq_ops", 32'(ops_retired), 32'd5);

    // 4: ANDS keeps C/V; ADC consumes stored carry
    msr(4'b0010);
    do_op(CC_AL, OP_AND, 1'b1, 4'd6, 32'hF0, 32'h0F, 1'b0, 4'h0);
    chk("t4_and_data", wb_data, 32'd0);
    chk("t4_and_flags", 32'(flags_nzcv), 32'b0110);
    accept();
    do_op(CC_AL, OP_ADC, 1'b0, 4'd7, 32'd1, 32'd1, 1'b0, 4'h0);
    chk("t4_adc_data", wb_data, 32'd3);
    chk("t4_adc_we", 32'(wb_we), 32'd1);
    accept();
    chk("t4_ops", 32'(ops_retired), 32'd7);

    // 5: back-pressure; new request held during RESP must be ignored
    do_op(CC_AL, OP_ADD, 1'b0, 4'd5, 32'h10, 32'h20, 1'b0, 4'h0);
    req_valid = 1'b1; req_a = 32'hDEAD; req_b = 32'hBEEF; req_rd = 4'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t5_hold_valid", 32'(wb_valid), 32'd1);
      chk("t5_hold_data", wb_data, 32'h30);
      chk("t5_hold_rd", 32'(wb_rd), 32'd5);
      chk("t5_hold_ready", 32'(req_ready), 32'd0);
    end
    chk("t5_hold_ops", 32'(ops_retired), 32'd7);
    req_valid = 1'b0;
    accept();
    chk("t5_ops", 32'(ops_retired), 32'd8);
    chk("t5_alu_a_kept", alu_a, 32'h10);

    // 6: EXEC flag update beats MSR; reset during EXEC discards op
    do_op(CC_AL, OP_CMP, 1'b0, 4'd1, 32'd1, 32'd2, 1'b1, 4'b1111);
    chk("t6_collide_flags", 32'(flags_nzcv), 32'b1000);
    accept();
    chk("t6_ops", 32'(ops_retired), 32'd9);
    req_cond = CC_AL; req_opcode = OP_MOV; req_s = 1'b1; req_rd = 4'd2;
    req_a = 32'd0; req_b = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t6_in_exec", 32'(dbg_state), 32'(ST_EXEC));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_flags", 32'(flags_nzcv), 32'd0);
    chk("t6_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("t6_rst_ops", 32'(ops_retired), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t6_no_wb", 32'(wb_valid), 32'd0);
    end
    chk("t6_ready", 32'(req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
